// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction memory combinationally and
// buffers fetched words with their PCs in a small in-order prefetch queue.
module instr_fetch_unit #(
    parameter int unsigned BITS_DATA   = 32,
    parameter int unsigned BITS_ADDR   = 7,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [BITS_ADDR-1:0] imem_addr,
    input  logic [BITS_DATA-1:0] imem_rd,
    input  logic                 redirect_valid,
    input  logic [BITS_ADDR-1:0] redirect_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BITS_DATA-1:0] out_instr,
    output logic [BITS_ADDR-1:0] out_pc,
    output logic                 misalign_err
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

    logic [BITS_ADDR-1:0] pc;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [BITS_DATA-1:0] q_instr [QUEUE_DEPTH];
    logic [BITS_ADDR-1:0] q_pc    [QUEUE_DEPTH];
    logic                 pop;
    logic                 push;

    assign imem_addr = pc;
    assign out_valid = (count != '0);
    assign out_instr = q_instr[rd_ptr];
    assign out_pc    = q_pc[rd_ptr];
    assign pop       = out_valid && out_ready;
    // A pop frees a slot at the same edge, so a full queue still accepts a fetch.
    assign push      = !redirect_valid && ((count < CNT_W'(QUEUE_DEPTH)) || pop);

    // QUEUE_DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc           <= BITS_ADDR'(RESET_PC);
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misalign_err <= 1'b0;
            for (int unsigned i = 0; i < QUEUE_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            pc           <= {redirect_pc[BITS_ADDR-1:2], 2'b00};
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            misalign_err <= (redirect_pc[1:0] != 2'b00);
        end else begin
            misalign_err <= 1'b0;
            if (push) begin
                q_instr[wr_ptr] <= imem_rd;
                q_pc[wr_ptr]    <= pc;
                wr_ptr          <= wr_ptr + PTR_W'(1);
                pc              <= pc + BITS_ADDR'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected {pc, word} pairs are queued as
// stimulus is planned and compared whenever decode accepts a head entry.
module tb_instr_fetch_unit;

    localparam int unsigned BITS_DATA   = 32;
    localparam int unsigned BITS_ADDR   = 7;
    localparam int unsigned QUEUE_DEPTH = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [BITS_ADDR-1:0] imem_addr;
    logic [BITS_DATA-1:0] imem_rd;
    logic                 redirect_valid;
    logic [BITS_ADDR-1:0] redirect_pc;
    logic                 out_valid;
    logic                 out_ready;
    logic [BITS_DATA-1:0] out_instr;
    logic [BITS_ADDR-1:0] out_pc;
    logic                 misalign_err;

    typedef struct packed {
        logic [BITS_ADDR-1:0] pc;
        logic [BITS_DATA-1:0] instr;
    } entry_t;

    entry_t exp_q[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    logic [BITS_DATA-1:0] imem [32];

    instr_fetch_unit #(
        .BITS_DATA  (BITS_DATA),
        .BITS_ADDR  (BITS_ADDR),
        .RESET_PC   (0),
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    assign imem_rd = imem[imem_addr[6:2]];

    function automatic logic [BITS_DATA-1:0] word_at(input logic [BITS_ADDR-1:0] addr);
        return 32'hC0DE_0000 | 32'(addr[6:2]);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_fetch(input logic [BITS_ADDR-1:0] addr);
        entry_t e;
        e.pc    = addr;
        e.instr = word_at(addr);
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Handshakes coinciding with a redirect are flushed, so they are not scored.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                entry_t e;
                e = exp_q.pop_front();
                check("sb_pc", 64'(out_pc), 64'(e.pc));
                check("sb_instr", 64'(out_instr), 64'(e.instr));
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) imem[i] = word_at(BITS_ADDR'(i * 4));
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        step(2);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_misalign", 64'(misalign_err), 64'd0);

        // Streaming with out_ready high from reset release.
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) expect_fetch(BITS_ADDR'(4 * k));
        step(1);
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_pc", 64'(out_pc), 64'd0);
        for (int k = 0; k < 6; k++) begin
            step(1);
            check("stream_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b0;
        step(1);
        check("full_head_pc", 64'(out_pc), 64'd24);
        check("full_addr", 64'(imem_addr), 64'd32);

        // Asynchronous reset with two entries queued.
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_addr", 64'(imem_addr), 64'd0);
        check("async_rst_pc", 64'(out_pc), 64'd0);
        step(1);
        rst_n = 1'b1;

        // Stall: queue saturates at QUEUE_DEPTH, fetch address holds.
        step(1);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_pc0", 64'(out_pc), 64'd0);
        step(1);
        check("stall_addr_a", 64'(imem_addr), 64'd8);
        step(3);
        check("stall_addr_b", 64'(imem_addr), 64'd8);
        check("stall_head_pc", 64'(out_pc), 64'd0);
        check("stall_head_instr", 64'(out_instr), 64'(word_at(7'd0)));
        check("stall_valid_held", 64'(out_valid), 64'd1);
        for (int k = 0; k < 4; k++) expect_fetch(BITS_ADDR'(4 * k));
        out_ready = 1'b1;
        step(4);

        // Redirect to 0x40 with queue full and out_ready high.
        redirect_valid = 1'b1;
        redirect_pc    = 7'h40;
        step(1);
        redirect_valid = 1'b0;
        check("redir_n1_valid", 64'(out_valid), 64'd0);
        check("redir_n1_addr", 64'(imem_addr), 64'h40);
        expect_fetch(7'h40);
        expect_fetch(7'h44);
        step(1);
        check("redir_n2_valid", 64'(out_valid), 64'd1);
        check("redir_n2_pc", 64'(out_pc), 64'h40);
        step(2);

        // Misaligned redirect to 0x22 resumes at 0x20.
        redirect_valid = 1'b1;
        redirect_pc    = 7'h22;
        step(1);
        redirect_valid = 1'b0;
        check("misalign_pulse", 64'(misalign_err), 64'd1);
        check("misalign_addr", 64'(imem_addr), 64'h20);
        check("misalign_valid", 64'(out_valid), 64'd0);
        expect_fetch(7'h20);
        expect_fetch(7'h24);
        step(1);
        check("misalign_clear", 64'(misalign_err), 64'd0);
        check("misalign_pc", 64'(out_pc), 64'h20);
        step(2);

        // Back-to-back redirects: last target wins, then wrap from 0x78.
        redirect_valid = 1'b1;
        redirect_pc    = 7'h10;
        step(1);
        redirect_pc    = 7'h78;
        step(1);
        redirect_valid = 1'b0;
        check("aligned_no_err", 64'(misalign_err), 64'd0);
        check("b2b_addr", 64'(imem_addr), 64'h78);
        expect_fetch(7'h78);
        expect_fetch(7'h7C);
        expect_fetch(7'h00);
        expect_fetch(7'h04);
        step(5);
        out_ready = 1'b0;
        step(2);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
